// File: rtl/ultrasonic_trigger_pkg.sv
// Shared state type, default timing constants and width helper for the ultrasonic ranging front end.
package ultrasonic_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_RISE,
      ECHO_HIGH,
      DONE
   } trig_state_t;

   localparam int unsigned CLK_HZ         = 10_000_000;
   localparam int unsigned TRIG_CYCLES    = 100;
   localparam int unsigned PERIOD_CYCLES  = 600_000;
   localparam int unsigned TIMEOUT_CYCLES = 380_000;

   // Counter width for a 0..n-1 range, never below one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ultrasonic_trigger_if.sv
// Control/status bundle between the ranging controller (slave) and its user (master).
interface ultrasonic_trigger_if;
   logic       enable;
   logic       echo_pin;
   logic       trig;
   logic       echo_out;
   logic       busy;
   logic       done;
   logic       timeout;
   logic       overrun;
   logic [7:0] meas_count;

   modport master (
      output enable, echo_pin,
      input  trig, echo_out, busy, done, timeout, overrun, meas_count
   );

   modport slave (
      input  enable, echo_pin,
      output trig, echo_out, busy, done, timeout, overrun, meas_count
   );
endinterface

// File: rtl/ultrasonic_trigger_echo_conditioner.sv
// Echo synchroniser; with ULTRASONIC_GLITCH_FILTER_EN the output only follows a level held FILTER_CYCLES cycles.
module echo_conditioner #(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned FILTER_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic echo_pin_i,
   output logic echo_s_o
);
   import ultrasonic_pkg::*;

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], echo_pin_i};
      end
   end

`ifdef ULTRASONIC_GLITCH_FILTER_EN
   localparam int unsigned FW = cnt_width(FILTER_CYCLES);

   logic          filt_q;
   logic [FW-1:0] fcnt_q;

   // Count consecutive cycles the synchronised level disagrees with the filtered one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filt_q <= 1'b0;
         fcnt_q <= '0;
      end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
         fcnt_q <= '0;
      end else if (fcnt_q == FW'(FILTER_CYCLES - 1)) begin
         filt_q <= sync_q[SYNC_STAGES-1];
         fcnt_q <= '0;
      end else begin
         fcnt_q <= fcnt_q + 1'b1;
      end
   end

   assign echo_s_o = filt_q;
`else
   assign echo_s_o = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/ultrasonic_trigger.sv
// Periodic trigger, window-gated echo forwarding and echo timeout for the ultrasonic ranger.
// Optional echo glitch filter selected by ULTRASONIC_GLITCH_FILTER_EN (inside echo_conditioner).
module ultrasonic_trigger #(
   parameter int unsigned TRIG_CYCLES    = ultrasonic_pkg::TRIG_CYCLES,
   parameter int unsigned PERIOD_CYCLES  = ultrasonic_pkg::PERIOD_CYCLES,
   parameter int unsigned TIMEOUT_CYCLES = ultrasonic_pkg::TIMEOUT_CYCLES,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned FILTER_CYCLES  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   ultrasonic_trigger_if.slave  bus
);
   import ultrasonic_pkg::*;

   localparam int unsigned PER_W = cnt_width(PERIOD_CYCLES);
   localparam int unsigned TO_W  = cnt_width(TIMEOUT_CYCLES);
   localparam int unsigned PW    = cnt_width(TRIG_CYCLES);

   trig_state_t      state_q;
   logic [PER_W-1:0] per_q, per_d;
   logic [TO_W-1:0]  to_q, to_inc;
   logic [PW-1:0]    pulse_q;
   logic [7:0]       meas_q;
   logic             trig_q, echo_out_q, busy_q, done_q, timeout_q, overrun_q;
   logic             echo_s, echo_prev_q;
   logic             tick, echo_rise, echo_fall, to_limit;

   echo_conditioner #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_echo_conditioner (
      .clk        (clk),
      .reset      (reset),
      .echo_pin_i (bus.echo_pin),
      .echo_s_o   (echo_s)
   );

   always_comb begin
      per_d     = (per_q == PER_W'(PERIOD_CYCLES - 1)) ? '0 : per_q + 1'b1;
      tick      = (per_q == '0);
      echo_rise = echo_s & ~echo_prev_q;
      echo_fall = ~echo_s & echo_prev_q;
      to_limit  = (to_q == TO_W'(TIMEOUT_CYCLES - 1));
      // Saturate so a rise on the limit cycle still times out in ECHO_HIGH next cycle.
      to_inc    = to_limit ? to_q : to_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         per_q <= '0;
      end else begin
         per_q <= per_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         to_q        <= '0;
         pulse_q     <= '0;
         meas_q      <= '0;
         trig_q      <= 1'b0;
         echo_out_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         overrun_q   <= 1'b0;
         echo_prev_q <= 1'b0;
      end else begin
         echo_prev_q <= echo_s;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         echo_out_q  <= 1'b0;
         overrun_q   <= tick && (state_q != IDLE);
         case (state_q)
            IDLE: begin
               if (tick && bus.enable) begin
                  state_q <= TRIG;
                  trig_q  <= 1'b1;
                  pulse_q <= '0;
                  busy_q  <= 1'b1;
               end
            end
            TRIG: begin
               if (pulse_q == PW'(TRIG_CYCLES - 1)) begin
                  state_q    <= WAIT_RISE;
                  trig_q     <= 1'b0;
                  to_q       <= '0;
                  echo_out_q <= echo_s;
               end else begin
                  pulse_q <= pulse_q + 1'b1;
               end
            end
            WAIT_RISE: begin
               if (echo_rise) begin
                  state_q    <= ECHO_HIGH;
                  to_q       <= to_inc;
                  echo_out_q <= echo_s;
               end else if (to_limit) begin
                  state_q   <= IDLE;
                  timeout_q <= 1'b1;
                  busy_q    <= 1'b0;
               end else begin
                  to_q       <= to_inc;
                  echo_out_q <= echo_s;
               end
            end
            ECHO_HIGH: begin
               // Fall is checked first: a fall on the limit cycle counts as done.
               if (echo_fall) begin
                  state_q <= DONE;
               end else if (to_limit) begin
                  state_q   <= IDLE;
                  timeout_q <= 1'b1;
                  busy_q    <= 1'b0;
               end else begin
                  to_q       <= to_inc;
                  echo_out_q <= echo_s;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b1;
               meas_q  <= meas_q + 8'd1;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               trig_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.trig       = trig_q;
   assign bus.echo_out   = echo_out_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.timeout    = timeout_q;
   assign bus.overrun    = overrun_q;
   assign bus.meas_count = meas_q;

endmodule
